count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
Control stage directly upstream of the lab up/down counter. It conditions three raw push-buttons: synchronise, debounce, rising-edge detect. It runs a run/pause/load state machine and a prescaler that produces single-cycle enable ticks. It drives the counter's load, enable and up_down inputs, and consumes the counter's co (terminal-count) output to stop in one-shot mode.

Parameters:
PRESCALE, 4, clk cycles between enable ticks while running (>=2)
PS_WIDTH, 16, prescaler counter width; PRESCALE-1 must fit
DB_CYCLES, 3, consecutive stable synchronised samples required to accept a button level change (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset: asynchronous, active-high
btn_start  input  1  raw start/pause button, asynchronous to clk
btn_dir  input  1  raw direction-toggle button, asynchronous to clk
btn_load  input  1  raw load button, asynchronous to clk
oneshot  input  1  level: 1 = stop at terminal count; 0 = free-run with wrap
co  input  1  from counter: count at terminal value for current direction (all-ones when up, zero when down)
load  output  1  one-cycle pulse to counter load
enable  output  1  one-cycle pulse to counter enable
up_down  output  1  direction to counter: 1 = up
state  output  2  current FSM state encoding
busy  output  1  1 when state == RUN

Behaviour:
- Reset values: load=0, enable=0, up_down=1, state=IDLE, busy=0. Prescaler=0, synchronisers and debounce filters=0, debounced levels=0.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: the debounced level changes only after DB_CYCLES consecutive synchronised samples differ from it. Any glitch restarts the count.
  - Pulse on debounced 0->1 transition: exactly one cycle per press.
  - Total latency from a clean edge to the pulse: 2 + DB_CYCLES + 1 cycles.
- States: IDLE=0, RUN=1, PAUSE=2, LOAD=3.
- IDLE:
  - load_p -> LOAD.
  - else start_p -> RUN.
- RUN:
  - oneshot && co -> IDLE (checked first).
  - else start_p -> PAUSE.
  - load_p is ignored.
- PAUSE:
  - load_p -> LOAD.
  - else start_p -> RUN.
- LOAD: load=1 for exactly this one cycle, then -> IDLE unconditionally. Button pulses arriving during LOAD are dropped.
- Direction: dir_p toggles up_down in every state, effective next cycle. An enable issued in the same cycle uses the old up_down value.
- Prescaler:
  - Held at 0 whenever state != RUN.
  - In RUN it counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1) && state == RUN.
  - First tick occurs exactly PRESCALE cycles after entering RUN. A pause restarts the period.
- enable = tick && !(oneshot && co). Registered output, so one cycle latency from the tick condition. It never asserts outside RUN.
- One-shot stop:
  - While in RUN, co=1 with oneshot=1 suppresses further enables.
  - FSM returns to IDLE on the next edge, even with no tick pending.
  - The counter therefore holds its terminal value.
- Free-run: with oneshot=0, co is ignored and the counter wraps.
- Outputs: load, enable and up_down are registered. state and busy reflect the state register.
- Reset mid-operation: asserting rst at any time immediately forces all reset values. A pending load/enable pulse is aborted.

Optional Feature:
COUNT_CTRL_AUTORELOAD_EN
- Defined: in RUN with oneshot && co, go to LOAD instead of IDLE. LOAD then returns to RUN (not IDLE) with the prescaler restarted, giving periodic terminal-and-reload operation. A manual LOAD from IDLE/PAUSE still returns to IDLE.
- Undefined: behaviour exactly as above; no extra logic.

Decomposition:
- Package count_ctrl_pkg holds:
  - state typedef/localparams IDLE, RUN, PAUSE, LOAD as 2-bit values;
  - default PRESCALE, DB_CYCLES and PS_WIDTH constants.
- Sub-module btn_cond (synchroniser + debounce + rising-edge pulse, parameter DB_CYCLES), instantiated three times.

Test Plan:
- Reset then idle 20 cycles -> up_down=1, load=enable=0, state=0, busy=0.
- btn_start bouncing 1/0/1 for 2 cycles, then held 1 (DB_CYCLES=3) -> exactly one start pulse; state=RUN; enable pulses every 4 cycles, first 4 cycles after RUN entry.
- In PAUSE, press btn_load and btn_start in the same cycle -> state LOAD for one cycle with load=1, then IDLE; no RUN entry.
- RUN with oneshot=1, force co=1 on the cycle a tick is due -> no enable pulse; next state IDLE; busy=0.
- RUN with oneshot=0, co=1 held -> enable continues every 4 cycles; btn_dir press -> up_down 1->0; an enable coincident with the toggle still sees up_down=1.
- rst pulsed while state=RUN and prescaler=2 -> all outputs return to reset values within the same cycle; no further enable.
- With COUNT_CTRL_AUTORELOAD_EN: oneshot=1, co=1 in RUN -> LOAD (load=1), then RUN; next enable 4 cycles later.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: state encoding and default parameters shared by the
// count_ctrl control stage and its button conditioner.
package count_ctrl_pkg;

  // FSM states; the encoding is visible on the state output port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LOAD  = 2'd3
  } state_t;

  // Default clk cycles between enable ticks while running.
  localparam int DEF_PRESCALE  = 4;
  // Default prescaler width; DEF_PRESCALE-1 must fit.
  localparam int DEF_PS_WIDTH  = 16;
  // Default number of stable samples needed to accept a button change.
  localparam int DEF_DB_CYCLES = 3;

endpackage

// File: rtl/count_ctrl_btn_cond.sv
// btn_cond: conditions one raw push-button into a single-cycle press pulse.
// Path: 2-flop synchroniser -> debounce filter -> registered rising-edge
// pulse. Latency from a clean raw edge to the pulse is 2 + DB_CYCLES + 1.
module btn_cond #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  // Counter holds 0..DB_CYCLES-1; keep at least one bit for DB_CYCLES=1.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync0;
  logic          sync1;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button input.
  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of its source and the chain really is two stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive samples
  // disagree with the current one; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync1 != level) begin
      if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered rising-edge detect on the debounced level: one cycle per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: control stage in front of the lab up/down counter.
// Conditions start/dir/load buttons, runs the IDLE/RUN/PAUSE/LOAD FSM and a
// prescaler, and drives the counter's load, enable and up_down inputs.
// Optional build macro COUNT_CTRL_AUTORELOAD_EN: a one-shot terminal count
// in RUN reloads the counter and resumes RUN instead of stopping in IDLE.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int PS_WIDTH  = DEF_PS_WIDTH,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dir,
  input  logic       btn_load,
  input  logic       oneshot,
  input  logic       co,
  output logic       load,
  output logic       enable,
  output logic       up_down,
  output logic [1:0] state,
  output logic       busy
);

  logic                start_p;
  logic                dir_p;
  logic                load_p;
  state_t              state_q;
  state_t              state_d;
  logic [PS_WIDTH-1:0] ps;
  logic                tick;
  logic                stop;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_start),
    .pulse (start_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_dir (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dir),
    .pulse (dir_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_load (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .pulse (load_p)
  );

  assign tick = (state_q == RUN) && (ps == PS_WIDTH'(PRESCALE - 1));
  assign stop = oneshot && co;

`ifdef COUNT_CTRL_AUTORELOAD_EN
  // Remembers that the current LOAD came from a terminal count in RUN.
  logic auto_ld;

  // Flag an automatic reload so LOAD knows to resume RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_ld <= 1'b0;
    end else begin
      auto_ld <= (state_q == RUN) && (state_d == LOAD);
    end
  end
`endif

  // Next-state logic; load has priority over start in IDLE and PAUSE.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_p)       state_d = LOAD;
        else if (start_p) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
          state_d = LOAD;
`else
          state_d = IDLE;
`endif
        end else if (start_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (load_p)       state_d = LOAD;
        else if (start_p) state_d = RUN;
      end
      LOAD: begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
        state_d = auto_ld ? RUN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, prescaler and registered counter-control outputs.
  // The prescaler only advances while staying in RUN, so it reads 0 in every
  // non-RUN cycle and each RUN entry restarts the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ps      <= '0;
      load    <= 1'b0;
      enable  <= 1'b0;
      up_down <= 1'b1;
    end else begin
      state_q <= state_d;
      if ((state_q == RUN) && (state_d == RUN)) begin
        ps <= tick ? '0 : ps + PS_WIDTH'(1);
      end else begin
        ps <= '0;
      end
      load    <= (state_d == LOAD);
      enable  <= tick && !stop && (state_d == RUN);
      up_down <= up_down ^ dir_p;
    end
  end

  assign state = state_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed self-checking bench for count_ctrl with default
// parameters (PRESCALE=4, DB_CYCLES=3). Outputs are sampled 1 time unit
// after each rising clock edge.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_dir;
  logic       btn_load;
  logic       oneshot;
  logic       co;
  logic       load;
  logic       enable;
  logic       up_down;
  logic [1:0] state;
  logic       busy;

  int checks = 0;
  int errors = 0;

  count_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_dir   (btn_dir),
    .btn_load  (btn_load),
    .oneshot   (oneshot),
    .co        (co),
    .load      (load),
    .enable    (enable),
    .up_down   (up_down),
    .state     (state),
    .busy      (busy)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever mis-specified.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until state equals target (bounded); returns just after the entry edge.
  task automatic wait_state(input state_t target, input int bound, input string tag);
    for (int i = 0; i < bound && state !== target; i++) step();
    check(tag, 16'(state), 16'(target));
  endtask

  initial begin
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_dir   = 1'b0;
    btn_load  = 1'b0;
    oneshot   = 1'b0;
    co        = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state held through 20 idle cycles.
    repeat (20) step();
    check("rst_up_down", 16'(up_down), 16'd1);
    check("rst_load",    16'(load),    16'd0);
    check("rst_enable",  16'(enable),  16'd0);
    check("rst_state",   16'(state),   16'(IDLE));
    check("rst_busy",    16'(busy),    16'd0);

    // Two-cycle press is one sample short of DB_CYCLES: rejected.
    btn_start = 1'b1;
    step();
    step();
    btn_start = 1'b0;
    repeat (15) step();
    check("short_press_ignored", 16'(state), 16'(IDLE));

    // Bouncing press 1/0/1 then held: exactly one start pulse -> RUN.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    btn_start = 1'b1;
    wait_state(RUN, 30, "bounce_to_run");
    check("run_busy", 16'(busy), 16'd1);
    btn_start = 1'b0;
    // Enable every 4 cycles, first one 4 cycles after RUN entry.
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("run_enable_%0d", k), 16'(enable), 16'((k % 4) == 0));
    end
    repeat (10) step();
    check("single_pulse_stays_run", 16'(state), 16'(RUN));

    // Start press in RUN -> PAUSE; no enables while paused.
    btn_start = 1'b1;
    wait_state(PAUSE, 30, "run_to_pause");
    btn_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("pause_no_enable", 16'(enable), 16'd0);
    end

    // Load and start in the same cycle from PAUSE: LOAD wins, then IDLE.
    btn_load  = 1'b1;
    btn_start = 1'b1;
    wait_state(LOAD, 30, "pause_to_load");
    check("load_pulse", 16'(load), 16'd1);
    step();
    check("load_to_idle", 16'(state), 16'(IDLE));
    check("load_pulse_end", 16'(load), 16'd0);
    repeat (10) step();
    check("load_no_run", 16'(state), 16'(IDLE));
    btn_load  = 1'b0;
    btn_start = 1'b0;
    repeat (10) step();

    // One-shot: co rises on the cycle a tick is due -> no enable, IDLE.
    oneshot   = 1'b1;
    btn_start = 1'b1;
    wait_state(RUN, 30, "oneshot_run");
    btn_start = 1'b0;
    repeat (3) step();
    co = 1'b1;
    step();
    check("oneshot_no_enable", 16'(enable), 16'd0);
    check("oneshot_idle",      16'(state),  16'(IDLE));
    check("oneshot_busy",      16'(busy),   16'd0);
    co      = 1'b0;
    oneshot = 1'b0;
    repeat (10) step();
    check("oneshot_stays_idle", 16'(state), 16'(IDLE));

    // Free-run with co held: enables continue; dir toggle coincides with
    // the second enable, which must still see up_down=1.
    co        = 1'b1;
    btn_start = 1'b1;
    wait_state(RUN, 30, "freerun_run");
    btn_start = 1'b0;
    step();
    step();
    btn_dir = 1'b1;
    step();
    step();
    check("freerun_en1",    16'(enable),  16'd1);
    check("freerun_dir1",   16'(up_down), 16'd1);
    repeat (3) step();
    check("freerun_gap",    16'(enable),  16'd0);
    step();
    check("freerun_en2",    16'(enable),  16'd1);
    check("en2_old_dir",    16'(up_down), 16'd1);
    step();
    check("dir_toggled",    16'(up_down), 16'd0);
    check("freerun_gap2",   16'(enable),  16'd0);
    btn_dir = 1'b0;
    repeat (3) step();
    check("freerun_en3",    16'(enable),  16'd1);
    check("freerun_state",  16'(state),   16'(RUN));

    // Reset mid-RUN with prescaler at 2: immediate return to reset values.
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_up_down", 16'(up_down), 16'd1);
    check("mid_rst_load",    16'(load),    16'd0);
    check("mid_rst_enable",  16'(enable),  16'd0);
    check("mid_rst_state",   16'(state),   16'(IDLE));
    check("mid_rst_busy",    16'(busy),    16'd0);
    step();
    rst = 1'b0;
    co  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("post_rst_no_enable", 16'(enable), 16'd0);
    end
    check("post_rst_idle", 16'(state), 16'(IDLE));

    // One-shot terminal count in RUN: autoreload or stop, per build.
    oneshot   = 1'b1;
    btn_start = 1'b1;
    wait_state(RUN, 30, "term_run");
    btn_start = 1'b0;
    step();
    co = 1'b1;
    step();
`ifdef COUNT_CTRL_AUTORELOAD_EN
    check("auto_load_state", 16'(state), 16'(LOAD));
    check("auto_load_pulse", 16'(load),  16'd1);
    co = 1'b0;
    step();
    check("auto_back_run",   16'(state), 16'(RUN));
    repeat (3) step();
    check("auto_no_early_en", 16'(enable), 16'd0);
    step();
    check("auto_enable",     16'(enable), 16'd1);
`else
    check("term_idle_state", 16'(state), 16'(IDLE));
    check("term_no_load",    16'(load),  16'd0);
    co = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
